// File: rtl/cfg_loader.sv
// rtl/cfg_loader.sv - serial configuration bitstream loader with sync hunt and even-parity commit
// Frame: SYNC_WORD, then CFG_BITS data bits MSB first, then one even-parity bit.
module cfg_loader #(
   parameter int          CFG_BITS  = 64,
   parameter logic [7:0]  SYNC_WORD = 8'hA5
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                bit_in,
   input  logic                bit_valid,
   output logic                bit_ready,
   output logic [CFG_BITS-1:0] cfg_out,
   output logic                cfg_update,
   output logic                cfg_done,
   output logic                cfg_error,
   output logic                busy
);

   localparam int CNT_W = $clog2(CFG_BITS + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CFG_BITS);

   typedef enum logic [2:0] {
      ST_HUNT  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_CHECK = 3'd2,
      ST_DONE  = 3'd3,
      ST_ERROR = 3'd4
   } state_t;

   state_t              state_q;
   logic [7:0]          sync_q;
   logic [7:0]          sync_d;
   logic [CFG_BITS-1:0] shadow_q;
   logic [CFG_BITS-1:0] cfg_q;
   logic [CNT_W-1:0]    cnt_q;
   logic                par_q;
   logic                ready_q;
   logic                update_q;
   logic                done_q;
   logic                error_q;
   logic                busy_q;
   logic                accept;

   assign accept = bit_valid & ready_q;
   assign sync_d = {sync_q[6:0], bit_in};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_HUNT;
         sync_q   <= '0;
         shadow_q <= '0;
         cfg_q    <= '0;
         cnt_q    <= '0;
         par_q    <= 1'b0;
         ready_q  <= 1'b1;
         update_q <= 1'b0;
         done_q   <= 1'b0;
         error_q  <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         update_q <= 1'b0;
         case (state_q)
            ST_HUNT, ST_DONE, ST_ERROR: begin
               if (accept) begin
                  // Detection uses the window including the bit arriving now.
                  if (sync_d == SYNC_WORD) begin
                     state_q <= ST_LOAD;
                     sync_q  <= '0;
                     cnt_q   <= '0;
                     par_q   <= 1'b0;
                     done_q  <= 1'b0;
                     error_q <= 1'b0;
                     busy_q  <= 1'b1;
                  end else begin
                     sync_q <= sync_d;
                  end
               end
            end
            ST_LOAD: begin
               if (accept) begin
                  par_q <= par_q ^ bit_in;
                  if (cnt_q == LAST_CNT) begin
                     state_q <= ST_CHECK;
                     ready_q <= 1'b0;
                  end else begin
                     shadow_q <= {shadow_q[CFG_BITS-2:0], bit_in};
                     cnt_q    <= cnt_q + 1'b1;
                  end
               end
            end
            ST_CHECK: begin
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
               if (!par_q) begin
                  cfg_q    <= shadow_q;
                  update_q <= 1'b1;
                  done_q   <= 1'b1;
                  error_q  <= 1'b0;
                  state_q  <= ST_DONE;
               end else begin
                  done_q  <= 1'b0;
                  error_q <= 1'b1;
                  state_q <= ST_ERROR;
               end
            end
            default: begin
               state_q <= ST_HUNT;
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bit_ready  = ready_q;
   assign cfg_out    = cfg_q;
   assign cfg_update = update_q;
   assign cfg_done   = done_q;
   assign cfg_error  = error_q;
   assign busy       = busy_q;

endmodule

// File: doc/cfg_loader.md
CFG_LOADER -- requirements
Module: cfg_loader

Interface
REQ-001 SHALL have parameter CFG_BITS, default 64, meaning the width of the configuration word delivered to downstream logic cells (LUT and DFF select bits); legal range 2..1024.
REQ-002 SHALL have parameter SYNC_WORD, default 8'hA5, meaning the 8-bit start pattern that precedes every frame.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset (asserted when 0).
REQ-005 SHALL have port bit_in, input, 1, serial bitstream data.
REQ-006 SHALL have port bit_valid, input, 1, meaning bit_in holds a valid bit.
REQ-007 SHALL have port bit_ready, output, 1, meaning the loader accepts a bit this cycle.
REQ-008 SHALL have port cfg_out, output, CFG_BITS, the last committed configuration word.
REQ-009 SHALL have port cfg_update, output, 1, a one-cycle pulse on the cycle cfg_out takes a new value.
REQ-010 SHALL have port cfg_done, output, 1, high while the last frame committed successfully.
REQ-011 SHALL have port cfg_error, output, 1, high while the last frame failed its parity check.
REQ-012 SHALL have port busy, output, 1, high in the LOAD and CHECK states.

Function
REQ-013 SHALL accept a bit only on a clk edge where bit_valid=1 and bit_ready=1; all other cycles leave the shifters and counters unchanged.
REQ-014 SHALL implement the states HUNT, LOAD, CHECK, DONE and ERROR.
REQ-015 SHALL drive bit_ready=1 in every state except CHECK, where it is 0.
REQ-016 In HUNT, DONE and ERROR, SHALL shift each accepted bit into the LSB of an 8-bit sync register.
REQ-017 SHALL move to LOAD on the edge where the updated sync register equals SYNC_WORD; overlapping patterns are detected.
REQ-018 On entering LOAD, SHALL clear the sync register, the bit counter and the running parity.
REQ-019 In LOAD, SHALL shift each of the first CFG_BITS accepted bits into the LSB of a shadow register, so the first bit received ends at the MSB.
REQ-020 In LOAD, SHALL treat accepted bit CFG_BITS+1 as the parity bit and move to CHECK.
REQ-021 SHALL size the bit counter to clog2(CFG_BITS+1) bits; the counter never wraps within a frame.
REQ-022 SHALL use even parity: the XOR of all CFG_BITS data bits plus the parity bit must equal 0.
REQ-023 CHECK SHALL last exactly one cycle.
REQ-024 On a parity pass, CHECK SHALL load cfg_out from the shadow register, pulse cfg_update in that same cycle, set cfg_done=1 and cfg_error=0, and go to DONE.
REQ-025 On a parity fail, CHECK SHALL leave cfg_out unchanged, keep cfg_update at 0, set cfg_error=1 and cfg_done=0, and go to ERROR.
REQ-026 The latency from acceptance of the parity bit to a valid cfg_out and cfg_update pulse SHALL be exactly 1 cycle.
REQ-027 cfg_out SHALL never expose a partially shifted shadow value.
REQ-028 In DONE and ERROR, SHALL hold cfg_done and cfg_error until the next SYNC_WORD detection, which clears both and enters LOAD.
REQ-029 In LOAD, SHALL ignore the SYNC_WORD pattern and treat it as data; there is no abort mid-frame except reset.
REQ-030 SHALL hold all state indefinitely while bit_valid=0 stalls a frame.

Reset
REQ-031 When reset=0, SHALL immediately, independent of clk, force state=HUNT, cfg_out=0, cfg_update=0, cfg_done=0, cfg_error=0, busy=0, and clear the sync register, shadow register, counter and parity.
REQ-032 After reset deasserts, bit_ready SHALL be 1 on the first cycle.
REQ-033 A reset during LOAD or CHECK SHALL discard the partial frame with no cfg_update pulse.

Verification (CFG_BITS=8, SYNC_WORD=8'hA5)
REQ-034 A good frame SHALL commit: stream 10100101, then data 11001010, then parity 0 -> cfg_out=8'hCA and cfg_update pulses 1 cycle after the parity bit; cfg_done=1, busy=0.
REQ-035 A bad parity bit SHALL be rejected: the same frame with parity 1 -> cfg_error=1, cfg_done=0, cfg_out keeps its previous value, no cfg_update pulse.
REQ-036 Stalls SHALL not disturb a frame: a good frame with bit_valid=0 gaps of 0-5 random cycles -> identical result to REQ-034; bit_ready=0 only in the CHECK cycle.
REQ-037 Sync detection SHALL handle noise and overlap: noise 0110 then 1010 0101 -> LOAD entered on the final sync bit; an A5 pattern inside the data is loaded as data (data 8'hA5, parity 0 -> cfg_out=8'hA5).
REQ-038 Reset mid-frame SHALL discard the frame: reset=0 after 4 data bits -> all outputs 0 asynchronously, no cfg_update pulse; a following good frame commits normally.
REQ-039 Reloading SHALL work back to back: from DONE with cfg_out=8'hCA, a second good frame with data 8'h0F and parity 0 -> cfg_out=8'h0F, one cfg_update pulse, cfg_done held at 1 except while that frame is in LOAD/CHECK.
